dcache_writeback_buffer: RTL and testbench

Buffers dirty 512-bit data-cache lines evicted by the data cache and drains them to the system bus as Sysbus write bursts, so the cache never stalls on the bus for a writeback. It sits between the data cache's eviction path and the bus, alongside the read-side memory controller, and takes the bus only when granted. A snoop port lets the arbiter forward a line that is still pending, so a refill never reads stale memory.

---
 rtl/wb_buf_pkg.sv | 23 ++
 rtl/wb_line_fifo.sv | 87 ++++++++
 rtl/dcache_writeback_buffer.sv | 139 +++++++++++++
 tb/tb_dcache_writeback_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_buf_pkg.sv
// Shared definitions for the data-cache writeback buffer.
// Holds the bus-side FSM state type, the Sysbus write tag and the line
// geometry constants used by dcache_writeback_buffer and wb_line_fifo.
package wb_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } wb_state_t;

    // A line address drops the byte offset within a 64-byte line.
    localparam int LINE_OFFSET_W = 6;
    localparam int LINE_ADDR_W   = 64 - LINE_OFFSET_W;

    localparam int DEF_BLOCKSZ        = 512;
    localparam int DEF_BUS_DATA_WIDTH = 64;
    localparam int WORDS_PER_LINE     = DEF_BLOCKSZ / DEF_BUS_DATA_WIDTH;
    localparam int BEAT_W             = $clog2(WORDS_PER_LINE);

    localparam logic [12:0] WRITE_TAG = {1'b1, 4'b0001, 8'h00};

endpackage

// File: rtl/wb_line_fifo.sv
// Circular FIFO of evicted lines {line address, line data} with a
// combinational snoop search.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_addr/data  enqueue at the tail (caller guarantees !full)
//   pop                   drop the head entry (caller guarantees !empty)
//   full, empty           occupancy status
//   head_addr, head_data  oldest entry
//   snoop_addr            line address to look up
//   snoop_hit, snoop_data newest valid matching entry, zero when none
module wb_line_fifo
    import wb_buf_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int BLOCKSZ = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [LINE_ADDR_W-1:0] push_addr,
    input  logic [BLOCKSZ-1:0]     push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [LINE_ADDR_W-1:0] head_addr,
    output logic [BLOCKSZ-1:0]     head_data,
    input  logic [LINE_ADDR_W-1:0] snoop_addr,
    output logic                   snoop_hit,
    output logic [BLOCKSZ-1:0]     snoop_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LINE_ADDR_W-1:0] mem_addr [DEPTH];
    logic [BLOCKSZ-1:0]     mem_data [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity comes from the counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Walk from head towards tail so a later (newer) match overrides an
    // older one; slots beyond the occupancy are ignored.
    logic [PTR_W-1:0] idx;
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        idx        = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem_addr[idx] == snoop_addr)) begin
                snoop_hit  = 1'b1;
                snoop_data = mem_data[idx];
            end
        end
    end

endmodule

// File: rtl/dcache_writeback_buffer.sv
// Writeback buffer between the data-cache eviction path and the Sysbus.
// Accepts dirty lines, queues them, and drains each one as a write burst
// (one address beat then WORDS_PER_LINE data beats) once the bus is granted.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wb_valid/wb_ready           eviction handshake (wb_ready = !full)
//   wb_addr, wb_data            evicted line address and data
//   snoop_addr/hit/data         combinational lookup of pending lines
//   bus_grant                   bus available, sampled only in IDLE
//   bus_busy                    burst in progress (ADDR or DATA)
//   bus_reqcyc/req/reqtag       current beat driven to the bus
//   bus_reqack                  bus accepted the current beat
//   empty                       no lines pending
module dcache_writeback_buffer
    import wb_buf_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int BLOCKSZ        = 512,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [63:0]               wb_addr,
    input  logic [BLOCKSZ-1:0]        wb_data,
    input  logic [63:0]               snoop_addr,
    output logic                      snoop_hit,
    output logic [BLOCKSZ-1:0]        snoop_data,
    input  logic                      bus_grant,
    output logic                      bus_busy,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    output logic                      empty
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    wb_state_t              state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic [LINE_ADDR_W-1:0] head_addr;
    logic [BLOCKSZ-1:0]     head_data;

    // Byte-offset bits of both address inputs carry no meaning here.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{wb_addr[LINE_OFFSET_W-1:0], snoop_addr[LINE_OFFSET_W-1:0]};

    // No same-cycle pop bypass: a full buffer refuses even while it pops.
    assign wb_ready = !full;
    assign push     = wb_valid && !full;

    wb_line_fifo #(
        .DEPTH   (DEPTH),
        .BLOCKSZ (BLOCKSZ)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_addr  (wb_addr[63:LINE_OFFSET_W]),
        .push_data  (wb_data),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .snoop_addr (snoop_addr[63:LINE_OFFSET_W]),
        .snoop_hit  (snoop_hit),
        .snoop_data (snoop_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Returning to IDLE after every pop guarantees at least one idle cycle
    // in which the memory controller can win the bus.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && bus_grant) state_d = ADDR;
            end
            ADDR: begin
                if (bus_reqack) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (bus_reqack) begin
                    if (beat_q == LAST_BEAT) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs decode only state, beat and stored head, never the ack.
    always_comb begin
        bus_reqcyc = 1'b0;
        bus_busy   = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        case (state_q)
            ADDR: begin
                bus_reqcyc = 1'b1;
                bus_busy   = 1'b1;
                bus_req    = BUS_DATA_WIDTH'({head_addr, {LINE_OFFSET_W{1'b0}}});
                bus_reqtag = BUS_TAG_WIDTH'(WRITE_TAG);
            end
            DATA: begin
                bus_reqcyc = 1'b1;
                bus_busy   = 1'b1;
                bus_req    = head_data[int'(beat_q) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
module tb_dcache_writeback_buffer;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         wb_valid;
    logic         wb_ready;
    logic [63:0]  wb_addr;
    logic [511:0] wb_data;
    logic [63:0]  snoop_addr;
    logic         snoop_hit;
    logic [511:0] snoop_data;
    logic         bus_grant;
    logic         bus_busy;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_reqack;
    logic         empty;

    always #5 clk = ~clk;

    dcache_writeback_buffer #(
        .DEPTH(DEPTH), .BLOCKSZ(512), .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
        .bus_grant(bus_grant), .bus_busy(bus_busy), .bus_reqcyc(bus_reqcyc),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .empty(empty)
    );

    // Reference model: pending lines in arrival order, plus the position
    // within the current write burst (0 idle, 1 address beat, 2..9 data
    // beats 0..7).
    typedef struct {
        logic [57:0]  a;
        logic [511:0] d;
    } line_t;

    line_t q[$];
    int    ph = 0;
    int    errs = 0;
    int    checks = 0;
    int    beats_seen = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mkline(input logic [63:0] base);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[k*64 +: 64] = base + 64'(k);
        return r;
    endfunction

    function automatic logic [511:0] fill(input logic [63:0] w);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[k*64 +: 64] = w;
        return r;
    endfunction

    function automatic logic [511:0] rnd_line();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // One clock: drive inputs after the falling edge, compare every output
    // against the model, then advance the model to what the rising edge
    // must produce.
    task automatic step(input logic v, input logic [63:0] a, input logic [511:0] d,
                        input logic [63:0] sa, input logic g, input logic k, input logic r);
        logic         e_hit;
        logic [511:0] e_sd;
        logic [511:0] hd;
        logic [63:0]  e_req;
        logic [12:0]  e_tag;
        logic         acc;
        line_t        n;
        @(negedge clk);
        wb_valid = v; wb_addr = a; wb_data = d; snoop_addr = sa;
        bus_grant = g; bus_reqack = k; reset = r;
        #1;
        e_hit = 1'b0; e_sd = '0;
        foreach (q[i]) if (q[i].a == sa[63:6]) begin e_hit = 1'b1; e_sd = q[i].d; end
        e_req = '0; e_tag = '0;
        if (ph == 1) begin
            e_req = {q[0].a, 6'b0};
            e_tag = 13'h1100;
        end else if (ph >= 2) begin
            hd = q[0].d;
            e_req = hd[(ph-2)*64 +: 64];
        end
        check("wb_ready",   512'(wb_ready),   512'(q.size() < DEPTH));
        check("empty",      512'(empty),      512'(q.size() == 0));
        check("snoop_hit",  512'(snoop_hit),  512'(e_hit));
        check("snoop_data", snoop_data,       e_sd);
        check("bus_reqcyc", 512'(bus_reqcyc), 512'(ph != 0));
        check("bus_busy",   512'(bus_busy),   512'(ph != 0));
        check("bus_req",    512'(bus_req),    512'(e_req));
        check("bus_reqtag", 512'(bus_reqtag), 512'(e_tag));
        if (r) begin
            q.delete();
            ph = 0;
        end else begin
            acc = v && (q.size() < DEPTH);
            if (ph == 9 && k) begin
                void'(q.pop_front());
                ph = 0;
                beats_seen++;
            end else if (ph >= 1 && k) begin
                ph++;
                beats_seen++;
            end else if (ph == 0 && g && q.size() > 0) begin
                ph = 1;
            end
            if (acc) begin
                n.a = a[63:6];
                n.d = d;
                q.push_back(n);
            end
        end
    endtask

    task automatic idle_cycles(input int n, input logic [63:0] sa, input logic g, input logic k);
        for (int i = 0; i < n; i++) step(1'b0, 64'h0, '0, sa, g, k, 1'b0);
    endtask

    initial begin
        int hold;
        logic [63:0] pool [4];
        pool[0] = 64'h1040; pool[1] = 64'h2080; pool[2] = 64'h3000; pool[3] = 64'hFFFF_0000_0000_00C0;

        // Reset and reset values.
        step(1'b0, 64'h0, '0, 64'h1040, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0, '0, 64'h1040, 1'b0, 1'b0, 1'b1);
        idle_cycles(2, 64'h1040, 1'b0, 1'b0);

        // Single eviction with an ack every cycle; offset bits are ignored.
        step(1'b1, 64'h1045, mkline(64'h1000), 64'h1040, 1'b0, 1'b0, 1'b0);
        idle_cycles(13, 64'h1040, 1'b1, 1'b1);
        check("beats_single", 512'(beats_seen), 512'(9));
        check("empty_after_single", 512'(empty), 512'(1));

        // Back-pressure: three withheld acks on the address beat and beat 4.
        step(1'b1, 64'h2080, mkline(64'h2000), 64'h2080, 1'b0, 1'b0, 1'b0);
        hold = 0;
        for (int i = 0; i < 24; i++) begin
            if ((ph == 1 || ph == 6) && hold < 3) begin
                hold++;
                step(1'b0, 64'h0, '0, 64'h2080, 1'b1, 1'b0, 1'b0);
            end else begin
                if (ph != 1 && ph != 6) hold = 0;
                else hold = 0;
                step(1'b0, 64'h0, '0, 64'h2080, 1'b1, 1'b1, 1'b0);
            end
        end
        check("beats_backpressure", 512'(beats_seen), 512'(18));

        // Fill while the bus is withheld; a third offer must be refused.
        step(1'b1, 64'h3000, mkline(64'h3000), 64'h3000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h4000, mkline(64'h4000), 64'h3000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h5000, mkline(64'h5000), 64'h5000, 1'b0, 1'b0, 1'b0);
        check("third_refused", 512'(q.size()), 512'(2));
        idle_cycles(24, 64'h4000, 1'b1, 1'b1);

        // Same-address evictions; the newer data wins both before and after
        // the first one drains.
        step(1'b1, 64'h6000, fill(64'hAA), 64'h6000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h6000, fill(64'hBB), 64'h6000, 1'b0, 1'b0, 1'b0);
        idle_cycles(12, 64'h6000, 1'b1, 1'b1);
        idle_cycles(12, 64'h6000, 1'b1, 1'b1);

        // Offer while full across the last-beat ack: refused, then accepted.
        step(1'b1, 64'h7000, mkline(64'h7000), 64'h7000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h8000, mkline(64'h8000), 64'h8000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b1, 64'h9000, mkline(64'h9000), 64'h9000, 1'b1, 1'b1, 1'b0);
        idle_cycles(24, 64'h9000, 1'b1, 1'b1);

        // Reset during data beat 3 abandons the burst.
        step(1'b1, 64'hA000, mkline(64'hA000), 64'hA000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12 && ph != 5; i++)
            step(1'b0, 64'h0, '0, 64'hA000, 1'b1, 1'b1, 1'b0);
        check("reached_beat3", 512'(ph), 512'(5));
        step(1'b0, 64'h0, '0, 64'hA000, 1'b1, 1'b1, 1'b1);
        idle_cycles(4, 64'hA000, 1'b1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 2) == 0),
                 pool[$urandom_range(0, 3)] | 64'($urandom_range(0, 63)),
                 rnd_line(),
                 pool[$urandom_range(0, 3)],
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
